// File: rtl/lt24_window_streamer.sv
`timescale 1ns/1ps
// lt24_window_streamer
//
// Streams one rectangular window of RGB565 pixels from a pixel memory to an
// ILI9341-style LT24 panel over a 16-bit 8080 write bus. A request sets the
// column range (CASET 0x2A), the page range (PASET 0x2B), then issues RAMWR
// (0x2C) followed by we*he pixel words read sequentially from address 0.
// The window is clipped to the panel; a fully clipped window completes at
// once with a done pulse and no bus or memory traffic.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, honoured only while idle
//   x0, y0, w, h        window origin and size, captured on an accepted start
//   busy, done          transfer in progress / one-cycle completion pulse
//   mem_*               read-only pixel memory port; data returns one cycle
//                       after the strobed address
//   lcd_cs_n, lcd_rs,
//   lcd_wr_n, lcd_rd_n,
//   lcd_d               8080 write bus to the panel
module lt24_window_streamer #(
    parameter int MEM_AW = 13,
    parameter int X_MAX  = 239,
    parameter int Y_MAX  = 319
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        x0,
    input  logic [8:0]        y0,
    input  logic [7:0]        w,
    input  logic [8:0]        h,
    output logic              busy,
    output logic              done,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic [15:0]       mem_writedata,
    input  logic [15:0]       mem_readdata,
    output logic              lcd_cs_n,
    output logic              lcd_rs,
    output logic              lcd_wr_n,
    output logic              lcd_rd_n,
    output logic [15:0]       lcd_d
);

    typedef enum logic [2:0] {
        IDLE, CASET_CMD, CASET_P, PASET_CMD, PASET_P, RAMWR_CMD, PIXEL, FINISH
    } state_t;

    // Selects byte i of the {start, end} coordinate pair, MSB first,
    // zero-extended to a full bus word.
    function automatic logic [15:0] param_byte(input logic [15:0] a,
                                               input logic [15:0] b,
                                               input logic [1:0]  i);
        logic [7:0] sel;
        case (i)
            2'd0:    sel = a[15:8];
            2'd1:    sel = a[7:0];
            2'd2:    sel = b[15:8];
            default: sel = b[7:0];
        endcase
        return {8'h00, sel};
    endfunction

    state_t      state;
    logic        setup;      // chip-select setup cycle before the first word
    logic        phase;      // 0: write strobe low, 1: strobe high, data held
    logic        pix_a;      // lcd_d follows mem_readdata this cycle
    logic [16:0] idx;
    logic [15:0] lcd_d_q;
    logic        mem_rd;

    logic [16:0] n_q;
    logic [15:0] x0_q, x1_q, y0_q, y1_q;

    // Clipping arithmetic kept wide so that an origin past the panel edge
    // yields zero room instead of wrapping.
    logic [17:0] x_room, y_room;
    logic [7:0]  we;
    logic [8:0]  he;
    logic [16:0] n_req;
    logic        empty;

    always_comb begin
        x_room = (18'(x0) > 18'(X_MAX)) ? 18'd0 : 18'(X_MAX + 1) - 18'(x0);
        y_room = (18'(y0) > 18'(Y_MAX)) ? 18'd0 : 18'(Y_MAX + 1) - 18'(y0);
        we     = (18'(w) < x_room) ? w : x_room[7:0];
        he     = (18'(h) < y_room) ? h : y_room[8:0];
        n_req  = we * he;
        empty  = (we == 8'd0) || (he == 9'd0);
    end

    // Word that follows the current one once its phase B completes.
    state_t      adv_state;
    logic [16:0] adv_idx;
    logic [15:0] adv_data;
    logic        adv_rs;
    logic        last_pix;

    always_comb begin
        adv_state = state;
        adv_idx   = '0;
        last_pix  = (idx == n_q - 17'd1);
        case (state)
            CASET_CMD: adv_state = CASET_P;
            CASET_P: begin
                if (idx == 17'd3) adv_state = PASET_CMD;
                else              adv_idx   = idx + 17'd1;
            end
            PASET_CMD: adv_state = PASET_P;
            PASET_P: begin
                if (idx == 17'd3) adv_state = RAMWR_CMD;
                else              adv_idx   = idx + 17'd1;
            end
            RAMWR_CMD: adv_state = PIXEL;
            PIXEL: begin
                if (last_pix) adv_state = FINISH;
                else          adv_idx   = idx + 17'd1;
            end
            default: adv_state = IDLE;
        endcase

        adv_data = 16'h0000;
        case (adv_state)
            CASET_P:   adv_data = param_byte(x0_q, x1_q, adv_idx[1:0]);
            PASET_CMD: adv_data = 16'h002B;
            PASET_P:   adv_data = param_byte(y0_q, y1_q, adv_idx[1:0]);
            RAMWR_CMD: adv_data = 16'h002C;
            default:   adv_data = 16'h0000;
        endcase
        adv_rs = !(adv_state inside {CASET_CMD, PASET_CMD, RAMWR_CMD});
    end

    // Window geometry is pure data: captured on an accepted start only.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !empty) begin
            x0_q <= 16'(x0);
            y0_q <= 16'(y0);
            x1_q <= 16'(x0) + 16'(we) - 16'd1;
            y1_q <= 16'(y0) + 16'(he) - 16'd1;
            n_q  <= n_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            setup       <= 1'b0;
            phase       <= 1'b0;
            pix_a       <= 1'b0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lcd_cs_n    <= 1'b1;
            lcd_wr_n    <= 1'b1;
            lcd_rs      <= 1'b1;
            lcd_d_q     <= 16'h0000;
            mem_rd      <= 1'b0;
            mem_address <= '0;
        end else begin
            done   <= 1'b0;
            mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (empty) begin
                            done <= 1'b1;
                        end else begin
                            state    <= CASET_CMD;
                            setup    <= 1'b1;
                            phase    <= 1'b0;
                            idx      <= '0;
                            busy     <= 1'b1;
                            lcd_cs_n <= 1'b0;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: begin
                    if (setup) begin
                        setup    <= 1'b0;
                        lcd_wr_n <= 1'b0;
                        lcd_rs   <= 1'b0;
                        lcd_d_q  <= 16'h002A;
                    end else if (!phase) begin
                        // Phase B: release the strobe, hold data, and fetch
                        // the next pixel so it arrives for the next phase A.
                        phase    <= 1'b1;
                        lcd_wr_n <= 1'b1;
                        pix_a    <= 1'b0;
                        if (pix_a) lcd_d_q <= mem_readdata;
                        if (state == RAMWR_CMD) begin
                            mem_rd      <= 1'b1;
                            mem_address <= '0;
                        end else if (state == PIXEL && !last_pix) begin
                            mem_rd      <= 1'b1;
                            mem_address <= mem_address + MEM_AW'(1);
                        end
                    end else begin
                        state <= adv_state;
                        idx   <= adv_idx;
                        phase <= 1'b0;
                        if (adv_state == FINISH) begin
                            lcd_cs_n <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            lcd_wr_n <= 1'b0;
                            lcd_rs   <= adv_rs;
                            lcd_d_q  <= adv_data;
                            pix_a    <= (adv_state == PIXEL);
                        end
                    end
                end
            endcase
        end
    end

    // Pixel data is only valid in the cycle it returns, so phase A passes it
    // straight through; phase B replays the registered copy.
    assign lcd_d          = pix_a ? mem_readdata : lcd_d_q;
    assign lcd_rd_n       = 1'b1;
    assign mem_chipselect = mem_rd;
    assign mem_clken      = mem_rd;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 2'b11;
    assign mem_writedata  = 16'h0000;

endmodule

// File: tb/tb_lt24_window_streamer.sv
`timescale 1ns/1ps
// Self-checking bench for lt24_window_streamer: directed and random windows
// compared against a word-list model of the panel bus and pixel memory.
module tb_lt24_window_streamer;

    localparam int MEM_AW    = 13;
    localparam int X_MAX     = 239;
    localparam int Y_MAX     = 319;
    localparam int MEM_WORDS = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        x0 = '0;
    logic [8:0]        y0 = '0;
    logic [7:0]        w = '0;
    logic [8:0]        h = '0;
    logic              busy, done;
    logic [MEM_AW-1:0] mem_address;
    logic              mem_chipselect, mem_clken, mem_write;
    logic [1:0]        mem_byteenable;
    logic [15:0]       mem_writedata;
    logic [15:0]       mem_readdata = '0;
    logic              lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0]       lcd_d;

    lt24_window_streamer #(.MEM_AW(MEM_AW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
        .lcd_rd_n(lcd_rd_n), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Pixel memory: data appears one cycle after a strobed address.
    logic [15:0] mem [MEM_WORDS];
    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

    // Bus monitor, sampled on the falling edge.
    logic [16:0] wq [$];
    int          aq [$];
    int          dq [$];
    int          viol, wr_low, cs_low, busy_high;
    logic        prev_wr = 1'b1;
    logic [15:0] last_d = '0;

    always @(negedge clk) begin
        if (!lcd_wr_n) begin
            wq.push_back({lcd_rs, lcd_d});
            last_d = lcd_d;
            wr_low++;
            if (lcd_cs_n) viol++;
        end else if (!prev_wr && lcd_d !== last_d) begin
            viol++;
        end
        prev_wr = lcd_wr_n;
        if (!lcd_cs_n) cs_low++;
        if (busy) busy_high++;
        if (mem_chipselect) aq.push_back(int'(mem_address));
        if (mem_chipselect !== mem_clken || lcd_rd_n !== 1'b1 || mem_write !== 1'b0 ||
            mem_byteenable !== 2'b11 || mem_writedata !== 16'h0000) viol++;
        if (done) dq.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete(); aq.delete(); dq.delete();
        viol = 0; wr_low = 0; cs_low = 0; busy_high = 0;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, ".busy"},     64'(busy), 64'(1'b0));
        check({p, ".done"},     64'(done), 64'(1'b0));
        check({p, ".cs_n"},     64'(lcd_cs_n), 64'(1'b1));
        check({p, ".wr_n"},     64'(lcd_wr_n), 64'(1'b1));
        check({p, ".rd_n"},     64'(lcd_rd_n), 64'(1'b1));
        check({p, ".rs"},       64'(lcd_rs), 64'(1'b1));
        check({p, ".lcd_d"},    64'(lcd_d), 64'(16'h0000));
        check({p, ".mem_cs"},   64'(mem_chipselect), 64'(1'b0));
        check({p, ".mem_clken"},64'(mem_clken), 64'(1'b0));
        check({p, ".mem_addr"}, 64'(mem_address), 64'(0));
    endtask

    function automatic logic [16:0] mk(input logic rs, input int v);
        logic [15:0] t;
        t = v[15:0];
        return {rs, t};
    endfunction

    // Runs one request and compares the whole transfer with the model.
    // extra_at >= 0 pulses a second (to-be-ignored) start that many cycles in.
    task automatic run_window(input string name, input int xi, input int yi,
                              input int wi, input int hi, input int extra_at);
        logic [16:0] exp_w [$];
        int          exp_a [$];
        int xr, yr, we, he, n, lat, t0, bad, first;
        xr = (xi > X_MAX) ? 0 : X_MAX + 1 - xi;
        yr = (yi > Y_MAX) ? 0 : Y_MAX + 1 - yi;
        we = (wi < xr) ? wi : xr;
        he = (hi < yr) ? hi : yr;
        n  = we * he;
        if (n > 0) begin
            exp_w.push_back(mk(1'b0, 'h2A));
            exp_w.push_back(mk(1'b1, xi >> 8));
            exp_w.push_back(mk(1'b1, xi & 255));
            exp_w.push_back(mk(1'b1, (xi + we - 1) >> 8));
            exp_w.push_back(mk(1'b1, (xi + we - 1) & 255));
            exp_w.push_back(mk(1'b0, 'h2B));
            exp_w.push_back(mk(1'b1, yi >> 8));
            exp_w.push_back(mk(1'b1, yi & 255));
            exp_w.push_back(mk(1'b1, (yi + he - 1) >> 8));
            exp_w.push_back(mk(1'b1, (yi + he - 1) & 255));
            exp_w.push_back(mk(1'b0, 'h2C));
            for (int k = 0; k < n; k++) begin
                exp_w.push_back({1'b1, mem[k % MEM_WORDS]});
                exp_a.push_back(k % MEM_WORDS);
            end
            lat = 22 + 2 * n + 2;
        end else begin
            lat = 1;
        end

        @(posedge clk); #1;
        clear_mon();
        t0 = cyc;
        x0 = 8'(xi); y0 = 9'(yi); w = 8'(wi); h = 9'(hi);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 8'($urandom); y0 = 9'($urandom); w = 8'($urandom); h = 9'($urandom);
        for (int i = 0; i < lat + 20; i++) begin
            if (dq.size() != 0) break;
            if (i == extra_at) begin
                x0 = 8'd0; y0 = 9'd0; w = 8'd3; h = 9'd3;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;

        check({name, ".done_count"}, 64'(dq.size()), 64'(1));
        check({name, ".latency"}, 64'((dq.size() > 0) ? dq[0] - t0 : -1), 64'(lat));
        check({name, ".word_count"}, 64'(wq.size()), 64'(exp_w.size()));
        bad = 0; first = -1;
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
            if (wq[i] !== exp_w[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        check({name, ".word_errors"}, 64'(bad), 64'(0));
        if (first >= 0) check({name, ".first_bad_word"}, 64'(wq[first]), 64'(exp_w[first]));
        check({name, ".addr_count"}, 64'(aq.size()), 64'(exp_a.size()));
        bad = 0;
        for (int i = 0; i < aq.size() && i < exp_a.size(); i++)
            if (aq[i] != exp_a[i]) bad++;
        check({name, ".addr_errors"}, 64'(bad), 64'(0));
        check({name, ".protocol"}, 64'(viol), 64'(0));
        if (n == 0) begin
            check({name, ".cs_low_cycles"}, 64'(cs_low), 64'(0));
            check({name, ".wr_low_cycles"}, 64'(wr_low), 64'(0));
            check({name, ".busy_cycles"}, 64'(busy_high), 64'(0));
        end else begin
            check({name, ".busy_cycles"}, 64'(busy_high), 64'(lat - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);

        // Asynchronous reset, then ten idle cycles.
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_async");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (10) @(posedge clk);
        #1 check_reset_vals("rst_idle");
        check("rst_idle.wr_low_cycles", 64'(wr_low), 64'(0));

        // Small 2x2 window with known pixels.
        mem[0] = 16'hF800; mem[1] = 16'h07E0; mem[2] = 16'h001F; mem[3] = 16'hFFFF;
        run_window("win2x2", 10, 20, 2, 2, -1);

        // Empty windows.
        run_window("w_zero", 10, 20, 0, 5, -1);
        run_window("x0_240", 240, 20, 5, 5, -1);
        run_window("y0_400", 3, 400, 5, 5, -1);

        // Clipped at the right edge, with an ignored start mid-transfer.
        run_window("clip_x", 230, 0, 20, 1, 10);

        // Large window wrapping the memory address.
        run_window("big", 0, 0, 240, 40, -1);

        // Random windows, including ones near the panel edges.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            run_window($sformatf("rand%0d", r), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 400)), int'($urandom_range(0, 12)),
                       int'($urandom_range(0, 8)), -1);
        end
        for (int r = 0; r < 3; r++)
            run_window($sformatf("edge%0d", r), int'($urandom_range(228, 245)),
                       int'($urandom_range(310, 325)), int'($urandom_range(1, 20)),
                       int'($urandom_range(1, 15)), -1);

        // Reset during the pixel phase.
        @(posedge clk); #1;
        clear_mon();
        x0 = 8'd5; y0 = 9'd5; w = 8'd6; h = 9'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (aq.size() >= 5) break;
            @(posedge clk); #1;
        end
        check("rst_mid.reached_pixels", 64'(aq.size() >= 5), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("rst_mid.no_done", 64'(dq.size()), 64'(0));
        check_reset_vals("rst_mid_after");
        run_window("after_rst", 100, 100, 1, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
